geofence_src: RTL

- Stimulus/result end of the geofence point-stream interface.
- Reads point sets from a synchronous ROM and streams each set (1 object point followed by 6 fence vertices) into the geofence engine on X/Y, one point per cycle.
- Waits for the engine's valid pulse, captures is_inside into a result buffer, then moves to the next set.
- Sits between the test-data ROM/result RAM and the geofence core.

---
 rtl/geofence_pkg.sv | 25 ++
 rtl/geofence_src_timer.sv | 33 +++
 rtl/geofence_src.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/geofence_pkg.sv
// Shared types and constants for the geofence point-stream source.
//   state_t  : source FSM states
//   point_t  : one {x,y} coordinate pair as packed in a ROM word
//   ERR_*    : bit positions inside the sticky err vector
package geofence_pkg;

    localparam int PTS_PER_SET    = 7;   // object point + 6 fence vertices
    localparam int COORD_W        = 10;
    localparam int ERR_TIMEOUT    = 0;   // engine never answered
    localparam int ERR_SEND_VALID = 1;   // engine strobed while we were still streaming

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREF,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

endpackage

// File: rtl/geofence_src_timer.sv
// WAIT-cycle counter for the geofence source.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : forces the count to zero (has priority over enable)
//   enable     : counts one WAIT cycle
//   tc         : high during the TIMEOUT-th enabled cycle since the last clear
module geofence_src_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // Count starts at 0 on the first WAIT cycle, so TIMEOUT-1 marks the last one.
    assign tc = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/geofence_src.sv
// Geofence point-stream source.
// Reads point sets from a synchronous ROM, streams each set (object point then
// fence vertices) on X/Y one point per cycle, waits for the engine result and
// writes it into the result buffer.
//   clk, reset          : clock, asynchronous active-low reset
//   start               : run request pulse, honoured in IDLE or DONE only
//   rom_addr / rom_data : ROM read port, data arrives one cycle after address
//   X, Y                : current point, zero outside SEND
//   valid, is_inside    : engine result strobe and value
//   res_we/addr/data    : one-cycle result write
//   busy, done, err     : status; err is sticky until the next start or reset
//
// Engine handshake: valid is a single-cycle strobe with no back-pressure.
// is_inside is meaningful only in a cycle where valid is high. A strobe in
// WAIT is captured; one in SEND only raises err[1]; anywhere else it is dropped.
module geofence_src
    import geofence_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int PTS      = PTS_PER_SET,
    parameter int TIMEOUT  = 1023,
    parameter int AW       = 8,
    localparam int SW      = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [AW-1:0]        rom_addr,
    input  logic [2*COORD_W-1:0] rom_data,
    output logic [COORD_W-1:0]   X,
    output logic [COORD_W-1:0]   Y,
    input  logic                 valid,
    input  logic                 is_inside,
    output logic                 res_we,
    output logic [SW-1:0]        res_addr,
    output logic                 res_data,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err
);

    localparam int KW = (PTS > 1) ? $clog2(PTS) : 1;

    if ((NUM_SETS * PTS) > (2 ** AW)) begin : g_bad_cfg
        $error("geofence_src: AW too small for NUM_SETS*PTS ROM words");
    end

    state_t          state_q, state_d;
    logic [SW-1:0]   set_q, set_d;
    logic [KW-1:0]   k_q, k_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [SW-1:0]   raddr_q, raddr_d;
    logic            rdata_q, rdata_d;
    logic [1:0]      err_q, err_d;
    logic            tc;
    logic            last_k, last_set;
    logic [AW-1:0]   next_base;
    point_t          pt;

    geofence_src_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != ST_WAIT),
        .enable (state_q == ST_WAIT),
        .tc     (tc)
    );

    assign pt        = rom_data;
    assign last_k    = (k_q == KW'(PTS - 1));
    assign last_set  = (set_q == SW'(NUM_SETS - 1));
    // Address of the next set's object point; parked on rom_addr during WAIT
    // so rom_data already holds it when the engine answers.
    assign next_base = AW'((32'(set_q) + 32'd1) * 32'(PTS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            set_q   <= '0;
            k_q     <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            raddr_q <= '0;
            rdata_q <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            raddr_q <= raddr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        k_d     = k_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        raddr_d = raddr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    set_d   = '0;
                    k_d     = '0;
                    addr_d  = '0;
                    err_d   = '0;
                    state_d = ST_PREF;
                end
            end
            ST_PREF: begin
                addr_d  = AW'(1);
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (valid) begin
                    err_d[ERR_SEND_VALID] = 1'b1;
                end
                if (last_k) begin
                    addr_d  = next_base;
                    state_d = ST_WAIT;
                end else begin
                    k_d    = k_q + KW'(1);
                    addr_d = addr_q + AW'(1);
                end
            end
            ST_WAIT: begin
                // valid wins over a timeout landing in the same cycle
                if (valid || tc) begin
                    we_d    = 1'b1;
                    raddr_d = set_q;
                    rdata_d = valid ? is_inside : 1'b0;
                    if (!valid) begin
                        err_d[ERR_TIMEOUT] = 1'b1;
                    end
                    if (last_set) begin
                        state_d = ST_DONE;
                    end else begin
                        set_d   = set_q + SW'(1);
                        k_d     = '0;
                        // rom_data already shows point 0; fetch point 1 now
                        addr_d  = addr_q + AW'(1);
                        state_d = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rom_addr = addr_q;
    assign X        = (state_q == ST_SEND) ? pt.x : '0;
    assign Y        = (state_q == ST_SEND) ? pt.y : '0;
    assign res_we   = we_q;
    assign res_addr = raddr_q;
    assign res_data = rdata_q;
    assign busy     = (state_q == ST_PREF) || (state_q == ST_SEND) || (state_q == ST_WAIT);
    assign done     = (state_q == ST_DONE);
    assign err      = err_q;

endmodule
